// File: rtl/game_369_pkg.sv
// Shared types and constants for the 369 game judge.
package game_369_pkg;

  localparam int unsigned VAL_W = 4;

  typedef enum logic [2:0] {
    WAIT0 = 3'd0,
    EXP3  = 3'd1,
    EXP6  = 3'd2,
    EXP9  = 3'd3,
    EXP13 = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam logic [VAL_W-1:0] V0  = 4'd0;
  localparam logic [VAL_W-1:0] V3  = 4'd3;
  localparam logic [VAL_W-1:0] V6  = 4'd6;
  localparam logic [VAL_W-1:0] V9  = 4'd9;
  localparam logic [VAL_W-1:0] V13 = 4'd13;

  // Counter value the judge expects in a given state; 0 when not tracking.
  function automatic logic [VAL_W-1:0] next_expected(input state_e st);
    logic [VAL_W-1:0] v;
    v = V0;
    case (st)
      EXP3:    v = V3;
      EXP6:    v = V6;
      EXP9:    v = V9;
      EXP13:   v = V13;
      default: v = V0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/digit_369_split.sv
// Combinational split of a 0..15 count into BCD digits plus the clap condition.
module digit_369_split
  import game_369_pkg::*;
(
  input  logic [VAL_W-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             is369
);

  logic ones_hit;
  logic tens_hit;

  // Values 10..15 carry a tens digit of 1; everything else is a single digit.
  always_comb begin
    tens = 4'd0;
    ones = 4'(count);
    if (count >= 4'd10) begin
      tens = 4'd1;
      ones = 4'(count - 4'd10);
    end
    ones_hit = (ones == 4'd3) || (ones == 4'd6) || (ones == 4'd9);
    tens_hit = (tens == 4'd3) || (tens == 4'd6) || (tens == 4'd9);
    is369    = ones_hit || tens_hit;
  end

endmodule

// File: rtl/game_369_judge.sv
// Judges the 369 counter stream: clap pulses, clap tally, BCD display digits
// and a sticky sequence-error flag.
module game_369_judge
  import game_369_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_valid,
  input  logic [VAL_W-1:0] count,
  output logic             clap,
  output logic [CNT_W-1:0] clap_cnt,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             locked,
  output logic             err,
  output logic [VAL_W-1:0] expected
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e     state_q;
  state_e     state_d;
  logic [3:0] tens_c;
  logic [3:0] ones_c;
  logic       is369_c;

  digit_369_split u_split (
    .count (count),
    .tens  (tens_c),
    .ones  (ones_c),
    .is369 (is369_c)
  );

  // Next-state: lock on 0, then any value other than the expected one is fatal.
  always_comb begin
    state_d = state_q;
    if (count_valid) begin
      case (state_q)
        WAIT0:   state_d = (count == V0)  ? EXP3  : WAIT0;
        EXP3:    state_d = (count == V3)  ? EXP6  : ERR;
        EXP6:    state_d = (count == V6)  ? EXP9  : ERR;
        EXP9:    state_d = (count == V9)  ? EXP13 : ERR;
        EXP13:   state_d = (count == V13) ? EXP6  : ERR;
        ERR:     state_d = ERR;
        default: state_d = ERR;
      endcase
    end
  end

  // State and registered outputs; status outputs follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT0;
      clap     <= 1'b0;
      clap_cnt <= '0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      locked   <= 1'b0;
      err      <= 1'b0;
      expected <= V0;
    end else begin
      state_q  <= state_d;
      clap     <= count_valid && is369_c;
      if (count_valid) begin
        tens <= tens_c;
        ones <= ones_c;
        if (is369_c && (clap_cnt != CNT_MAX)) begin
          clap_cnt <= clap_cnt + CNT_W'(1);
        end
      end
      locked   <= (state_d != WAIT0);
      err      <= (state_d == ERR);
      expected <= next_expected(state_d);
    end
  end

endmodule

// File: tb/tb_game_369_judge.sv
// Self-checking bench for game_369_judge: directed table, hand-written corner
// sequences and randomized traffic against a sequence-level reference model.
module tb_game_369_judge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       count_valid = 1'b0;
  logic [3:0] count = 4'd0;

  logic       clap, clap_s;
  logic [7:0] clap_cnt;
  logic [1:0] clap_cnt_s;
  logic [3:0] tens, ones, tens_s, ones_s, expected, expected_s;
  logic       locked, err, locked_s, err_s;

  int n_cmp = 0;
  int n_bad = 0;

  game_369_judge #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .count_valid(count_valid), .count(count),
    .clap(clap), .clap_cnt(clap_cnt), .tens(tens), .ones(ones),
    .locked(locked), .err(err), .expected(expected)
  );

  // Narrow-tally instance sharing the stimulus, to exercise saturation.
  game_369_judge #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .count_valid(count_valid), .count(count),
    .clap(clap_s), .clap_cnt(clap_cnt_s), .tens(tens_s), .ones(ones_s),
    .locked(locked_s), .err(err_s), .expected(expected_s)
  );

  always #5 clk = ~clk;

  // Reference model: position in the legal sequence 0,3,6,9,13,(6,9,13)*.
  int legal [5] = '{0, 3, 6, 9, 13};
  int m_pos, m_cnt, m_cnt_sat, m_tens, m_ones;
  bit m_locked, m_err, m_clap;

  function automatic int next_pos(input int p);
    return (p == 4) ? 2 : p + 1;
  endfunction

  function automatic int m_expected();
    return (m_locked && !m_err) ? legal[next_pos(m_pos)] : 0;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int c);
    if (rst) begin
      m_pos = 0; m_cnt = 0; m_cnt_sat = 0; m_tens = 0; m_ones = 0;
      m_locked = 0; m_err = 0; m_clap = 0;
    end else begin
      m_clap = 0;
      if (v) begin
        m_tens = c / 10;
        m_ones = c % 10;
        m_clap = (m_tens inside {3, 6, 9}) || (m_ones inside {3, 6, 9});
        if (m_clap) begin
          if (m_cnt < 255) m_cnt++;
          if (m_cnt_sat < 3) m_cnt_sat++;
        end
        if (!m_locked) begin
          if (c == 0) begin m_locked = 1; m_pos = 0; end
        end else if (!m_err) begin
          if (c == legal[next_pos(m_pos)]) m_pos = next_pos(m_pos);
          else m_err = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_model();
    chk("clap", int'(clap), int'(m_clap));
    chk("clap_cnt", int'(clap_cnt), m_cnt);
    chk("tens", int'(tens), m_tens);
    chk("ones", int'(ones), m_ones);
    chk("locked", int'(locked), int'(m_locked));
    chk("err", int'(err), int'(m_err));
    chk("expected", int'(expected), m_expected());
    chk("sat_clap_cnt", int'(clap_cnt_s), m_cnt_sat);
    chk("sat_err", int'(err_s), int'(m_err));
  endtask

  // One clock: drive, let the edge happen, update model, sample on the falling edge.
  task automatic cycle(input bit rst, input bit v, input int c);
    reset = rst;
    count_valid = v;
    count = 4'(c);
    @(posedge clk);
    model_step(rst, v, c);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit rst; bit v; int c;
    int clap; int cnt; int tens; int ones; int locked; int err; int expd;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit rst, input bit v, input int c, input int cl, input int cn,
                     input int t, input int o, input int lk, input int er, input int ex);
    vec_t r;
    r.rst = rst; r.v = v; r.c = c; r.clap = cl; r.cnt = cn; r.tens = t; r.ones = o;
    r.locked = lk; r.err = er; r.expd = ex;
    tbl.push_back(r);
  endtask

  initial begin
    // Legal run 0,3,6,9,13,6,9,13.
    add(1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0, 0, 1, 0, 3);
    add(0, 1, 3,  1, 1, 0, 3, 1, 0, 6);
    add(0, 1, 6,  1, 2, 0, 6, 1, 0, 9);
    add(0, 1, 9,  1, 3, 0, 9, 1, 0, 13);
    add(0, 1, 13, 1, 4, 1, 3, 1, 0, 6);
    add(0, 1, 6,  1, 5, 0, 6, 1, 0, 9);
    add(0, 1, 9,  1, 6, 0, 9, 1, 0, 13);
    add(0, 1, 13, 1, 7, 1, 3, 1, 0, 6);
    // Unlocked junk then lock.
    add(1, 1, 9,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 5,  0, 0, 0, 5, 0, 0, 0);
    add(0, 1, 12, 0, 0, 1, 2, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0, 0, 1, 0, 3);
    add(0, 1, 3,  1, 1, 0, 3, 1, 0, 6);
    // Deviation 10 after 0,3,6; ERR still claps.
    add(1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0, 0, 1, 0, 3);
    add(0, 1, 3,  1, 1, 0, 3, 1, 0, 6);
    add(0, 1, 6,  1, 2, 0, 6, 1, 0, 9);
    add(0, 1, 10, 0, 2, 1, 0, 1, 1, 0);
    add(0, 1, 9,  1, 3, 0, 9, 1, 1, 0);
    // Repeated value is an error.
    add(1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0, 0, 1, 0, 3);
    add(0, 1, 3,  1, 1, 0, 3, 1, 0, 6);
    add(0, 1, 3,  1, 2, 0, 3, 1, 1, 0);
    // Upstream restart (0 while locked) is an error.
    add(1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0, 0, 1, 0, 3);
    add(0, 1, 0,  0, 0, 0, 0, 1, 1, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].c);
      chk($sformatf("tbl%0d_clap", i), int'(clap), tbl[i].clap);
      chk($sformatf("tbl%0d_cnt", i), int'(clap_cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d_tens", i), int'(tens), tbl[i].tens);
      chk($sformatf("tbl%0d_ones", i), int'(ones), tbl[i].ones);
      chk($sformatf("tbl%0d_locked", i), int'(locked), tbl[i].locked);
      chk($sformatf("tbl%0d_err", i), int'(err), tbl[i].err);
      chk($sformatf("tbl%0d_expected", i), int'(expected), tbl[i].expd);
      chk($sformatf("tbl%0d_sat", i), int'(clap_cnt_s), (tbl[i].cnt > 3) ? 3 : tbl[i].cnt);
    end

    // Saturation: narrow tally reads 1,2,3,3,3 on the clapping samples.
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    begin
      int seq [5] = '{3, 6, 9, 13, 6};
      int req [5] = '{1, 2, 3, 3, 3};
      for (int k = 0; k < 5; k++) begin
        cycle(0, 1, seq[k]);
        chk("sat_seq", int'(clap_cnt_s), req[k]);
      end
    end

    // Reset together with a valid 9 while expecting 9.
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 3);
    cycle(0, 1, 6);
    chk("pre_rst_expected", int'(expected), 9);
    cycle(1, 1, 9);
    chk("rst_wins_cnt", int'(clap_cnt), 0);
    chk("rst_wins_ones", int'(ones), 0);
    chk("rst_wins_expected", int'(expected), 0);
    chk("rst_wins_locked", int'(locked), 0);

    // Idle gap between 3 and 6.
    cycle(0, 1, 0);
    cycle(0, 1, 3);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 7);
      chk("gap_clap", int'(clap), 0);
      chk("gap_ones", int'(ones), 3);
      chk("gap_err", int'(err), 0);
    end
    cycle(0, 1, 6);
    chk("after_gap_clap", int'(clap), 1);
    chk("after_gap_cnt", int'(clap_cnt), 2);

    // Randomized traffic, mostly legal with occasional faults and resets.
    cycle(1, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      bit r, v;
      int c;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 90) c = m_locked ? legal[next_pos(m_pos)] : 0;
      else c = $urandom_range(0, 15);
      if (!m_locked && $urandom_range(0, 3) == 0) c = $urandom_range(0, 15);
      cycle(r, v, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
